// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing constants for the risk core register file
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 2 ** ADDR_W;
  localparam int ZERO_IDX = 0;
endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one registered read port: zero check, write-first bypass, output register
module regfile_rdport #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] sel,
  input  logic [ADDR_W-1:0] selwr,
  input  logic [DATA_W-1:0] wrval,
  input  logic [DATA_W-1:0] regval,
  output logic [DATA_W-1:0] q
);
  import regfile_pkg::ZERO_IDX;

  logic              zero_sel;
  logic              bypass;
  logic [DATA_W-1:0] nxt;

  assign zero_sel = (sel == ADDR_W'(ZERO_IDX));
  // zero_sel already excludes selwr == 0, so x0 writes never bypass
  assign bypass   = wr && !zero_sel && (sel == selwr);

  always_comb begin
    nxt = regval;
    if (zero_sel) begin
      nxt = '0;
    end else if (bypass) begin
      nxt = wrval;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (rd) begin
      q <= nxt;
    end
  end
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, one synchronous write port, two registered read ports
module regfile #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] selwr,
  input  logic [ADDR_W-1:0] selrd1,
  input  logic [ADDR_W-1:0] selrd2,
  input  logic [DATA_W-1:0] wrval,
  output logic [DATA_W-1:0] rdval1,
  output logic [DATA_W-1:0] rdval2
);
  import regfile_pkg::ZERO_IDX;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // x0 is never written, so its entry stays at the reset value of zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr && (selwr != ADDR_W'(ZERO_IDX))) begin
      regs[selwr] <= wrval;
    end
  end

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
    .clk    (clk),
    .rst    (rst),
    .rd     (rd),
    .wr     (wr),
    .sel    (selrd1),
    .selwr  (selwr),
    .wrval  (wrval),
    .regval (regs[selrd1]),
    .q      (rdval1)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
    .clk    (clk),
    .rst    (rst),
    .rd     (rd),
    .wr     (wr),
    .sel    (selrd2),
    .selwr  (selwr),
    .wrval  (wrval),
    .regval (regs[selrd2]),
    .q      (rdval2)
  );
endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - scoreboard bench for regfile: directed plan plus randomized traffic
module tb_regfile;
  logic        clk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [4:0]  selwr;
  logic [4:0]  selrd1;
  logic [4:0]  selrd2;
  logic [31:0] wrval;
  logic [31:0] rdval1;
  logic [31:0] rdval2;

  regfile dut (
    .rst    (rst),
    .clk    (clk),
    .wr     (wr),
    .rd     (rd),
    .selwr  (selwr),
    .selrd1 (selrd1),
    .selrd2 (selrd2),
    .wrval  (wrval),
    .rdval1 (rdval1),
    .rdval2 (rdval2)
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          n;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [32];
  logic [31:0] out1;
  logic [31:0] out2;
  int          n_checks;
  int          n_pass;
  int          n_edge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rdmodel(input logic [4:0] s, input logic w,
                                          input logic [4:0] sw, input logic [31:0] wv);
    if (s == 5'd0) return 32'd0;
    if (w && s == sw) return wv;
    return mem[s];
  endfunction

  // Drive one edge's inputs, advance the reference model, queue the expected outputs
  task automatic step(input logic r, input logic w, input logic d, input logic [4:0] sw,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] wv);
    exp_t e;
    @(negedge clk);
    rst = r; wr = w; rd = d; selwr = sw; selrd1 = s1; selrd2 = s2; wrval = wv;
    if (r) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      out1 = 32'd0;
      out2 = 32'd0;
    end else begin
      if (d) begin
        out1 = rdmodel(s1, w, sw, wv);
        out2 = rdmodel(s2, w, sw, wv);
      end
      if (w && sw != 5'd0) mem[sw] = wv;
    end
    e.r1 = out1;
    e.r2 = out2;
    e.n  = n_edge;
    n_edge++;
    sbq.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_checks++;
        if (rdval1 === e.r1) n_pass++;
        else $display("FAIL rdval1 edge %0d: got %h expected %h", e.n, rdval1, e.r1);
        n_checks++;
        if (rdval2 === e.r2) n_pass++;
        else $display("FAIL rdval2 edge %0d: got %h expected %h", e.n, rdval2, e.r2);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired with %0d expectations pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; n_edge = 0;
    out1 = 32'd0; out2 = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    selwr = 5'd0; selrd1 = 5'd0; selrd2 = 5'd0; wrval = 32'd0;

    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    step(1'b1, 1'b1, 1'b1, 5'd1, 5'd1, 5'd2, 32'h1234);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 32'd0);

    step(1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd10);
    step(1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0, 32'd21);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 32'd0);
    idle();
    idle();

    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);

    step(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd1, 32'h55);
    idle();

    step(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd7);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd1, 32'd0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd5, 32'd0);

    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 32'(k));
    end
    idle();

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom);
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 1'b1, 5'($urandom_range(0, 31)), 5'(k % 32), 5'((k + 7) % 32), 32'd0);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
